// File: rtl/rom_bus_responder_if.sv
// Backing-memory read port of the ROM bus responder.
// One request in flight; mem_valid_in pulses once per mem_req_out.
interface rom_bus_responder_if;
    logic [15:0] mem_addr_out;
    logic        mem_req_out;
    logic [7:0]  mem_data_in;
    logic        mem_valid_in;

    modport master (
        output mem_addr_out,
        output mem_req_out,
        input  mem_data_in,
        input  mem_valid_in
    );

    modport slave (
        input  mem_addr_out,
        input  mem_req_out,
        output mem_data_in,
        output mem_valid_in
    );
endinterface

// File: rtl/rom_bus_responder.sv
// Cartridge-side responder for the multiplexed 8-bit ROM bus.
// Latches the high byte, settles the low byte, fetches and presents data.
module rom_bus_responder #(
    parameter int unsigned TOTAL_ADDRESSES = 65536,
    parameter int unsigned SETTLE_CYCLES   = 2,
    parameter logic [7:0]  FILL_BYTE       = 8'hFF
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [7:0]                 bus_addr_in,
    input  logic                       bus_latcher_in,
    output logic [7:0]                 bus_data_out,
    rom_bus_responder_if.master        mem,
    output logic [7:0]                 addr_high_out,
    output logic                       busy_out,
    output logic [15:0]                read_count_out
);

    localparam logic [16:0] TOTAL  = 17'(TOTAL_ADDRESSES);
    localparam logic [3:0]  SETTLE = 4'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_REQUEST,
        S_WAIT
    } state_t;

    state_t      state;
    logic [7:0]  addr_s1;
    logic [7:0]  addr_s2;
    logic [7:0]  addr_d;
    logic        lat_s1;
    logic        lat_s2;
    logic        lat_d;
    logic [3:0]  cnt;
    logic        dirty;
    logic [15:0] last_addr;
    logic        last_valid;

    logic        latch_ev;
    logic        addr_chg;
    logic        bus_evt;
    logic [15:0] full_addr;
    logic        out_of_range;
    logic        same_as_last;

    assign latch_ev     = lat_s2 & ~lat_d;
    assign addr_chg     = (addr_s2 != addr_d) & ~lat_s2;
    assign bus_evt      = latch_ev | addr_chg;
    assign full_addr    = {addr_high_out, addr_s2};
    assign out_of_range = {1'b0, full_addr} >= TOTAL;
    assign same_as_last = last_valid && (full_addr == last_addr);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state            <= S_IDLE;
            addr_s1          <= '0;
            addr_s2          <= '0;
            addr_d           <= '0;
            lat_s1           <= 1'b0;
            lat_s2           <= 1'b0;
            lat_d            <= 1'b0;
            cnt              <= '0;
            dirty            <= 1'b0;
            last_addr        <= '0;
            last_valid       <= 1'b0;
            bus_data_out     <= FILL_BYTE;
            mem.mem_addr_out <= '0;
            mem.mem_req_out  <= 1'b0;
            addr_high_out    <= '0;
            busy_out         <= 1'b0;
            read_count_out   <= '0;
        end else begin
            addr_s1         <= bus_addr_in;
            addr_s2         <= addr_s1;
            addr_d          <= addr_s2;
            lat_s1          <= bus_latcher_in;
            lat_s2          <= lat_s1;
            lat_d           <= lat_s2;
            mem.mem_req_out <= 1'b0;

            if (latch_ev) begin
                addr_high_out <= addr_s2;
            end

            unique case (state)
                S_IDLE: begin
                    if (bus_evt) begin
                        cnt      <= '0;
                        state    <= S_SETTLE;
                        busy_out <= 1'b1;
                    end
                end

                S_SETTLE: begin
                    if (bus_evt) begin
                        cnt <= '0;
                    end else if (cnt == SETTLE) begin
                        if (out_of_range) begin
                            bus_data_out   <= FILL_BYTE;
                            read_count_out <= read_count_out + 16'd1;
                            last_valid     <= 1'b0;
                            state          <= S_IDLE;
                            busy_out       <= 1'b0;
                        end else if (same_as_last) begin
                            state    <= S_IDLE;
                            busy_out <= 1'b0;
                        end else begin
                            mem.mem_req_out  <= 1'b1;
                            mem.mem_addr_out <= full_addr;
                            dirty            <= 1'b0;
                            state            <= S_REQUEST;
                        end
                    end else if (!lat_s2) begin
                        cnt <= cnt + 4'd1;
                    end
                end

                // Bus activity seen from here on poisons the fetched byte.
                S_REQUEST: begin
                    dirty <= bus_evt;
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    if (mem.mem_valid_in) begin
                        dirty <= 1'b0;
                        if (dirty || bus_evt) begin
                            cnt   <= '0;
                            state <= S_SETTLE;
                        end else begin
                            bus_data_out   <= mem.mem_data_in;
                            last_addr      <= mem.mem_addr_out;
                            last_valid     <= 1'b1;
                            read_count_out <= read_count_out + 16'd1;
                            state          <= S_IDLE;
                            busy_out       <= 1'b0;
                        end
                    end else if (bus_evt) begin
                        dirty <= 1'b1;
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_bus_responder.sv
// Bench for rom_bus_responder: reader-timed stimulus, variable-latency
// memory model and a commit scoreboard.
module tb_rom_bus_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [7:0]  bus_addr = '0;
    logic        bus_lat = 1'b0;
    logic [7:0]  bus2_addr = '0;
    logic        bus2_lat = 1'b0;
    logic [7:0]  bus_data, bus2_data;
    logic [7:0]  ahi, ahi2;
    logic        busy, busy2;
    logic [15:0] cnt, cnt2;

    rom_bus_responder_if mif();
    rom_bus_responder_if mif2();

    assign mif2.mem_data_in  = 8'h00;
    assign mif2.mem_valid_in = 1'b0;

    rom_bus_responder dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .bus_addr_in    (bus_addr),
        .bus_latcher_in (bus_lat),
        .bus_data_out   (bus_data),
        .mem            (mif.master),
        .addr_high_out  (ahi),
        .busy_out       (busy),
        .read_count_out (cnt)
    );

    rom_bus_responder #(
        .TOTAL_ADDRESSES (256)
    ) dut2 (
        .clk_in         (clk),
        .rst_in         (rst),
        .bus_addr_in    (bus2_addr),
        .bus_latcher_in (bus2_lat),
        .bus_data_out   (bus2_data),
        .mem            (mif2.master),
        .addr_high_out  (ahi2),
        .busy_out       (busy2),
        .read_count_out (cnt2)
    );

    int          checks = 0;
    int          errors = 0;
    int          lat = 1;
    int          req_n = 0;
    int          req2_n = 0;
    logic [15:0] last_req = '0;
    logic [15:0] prev_cnt = '0;
    logic [7:0]  sb[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_fn(input logic [15:0] a);
        if (a == 16'h1234) return 8'hA5;
        return a[7:0] ^ a[15:8];
    endfunction

    // Reader: high byte, 1-cycle latch pulse, then low byte
    task automatic rd_present(input bit second, input logic [15:0] a);
        @(posedge clk);
        #1;
        if (second) bus2_addr = a[15:8];
        else bus_addr = a[15:8];
        @(posedge clk);
        #1;
        if (second) bus2_lat = 1'b1;
        else bus_lat = 1'b1;
        @(posedge clk);
        #1;
        if (second) bus2_lat = 1'b0;
        else bus_lat = 1'b0;
        @(posedge clk);
        #1;
        if (second) bus2_addr = a[7:0];
        else bus_addr = a[7:0];
    endtask

    initial begin
        logic [15:0] a;
        mif.mem_valid_in = 1'b0;
        mif.mem_data_in  = '0;
        forever begin
            @(negedge clk);
            if (mif.mem_req_out) begin
                a = mif.mem_addr_out;
                repeat (lat) @(posedge clk);
                #1;
                mif.mem_valid_in = 1'b1;
                mif.mem_data_in  = mem_fn(a);
                @(posedge clk);
                #1;
                mif.mem_valid_in = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (mif.mem_req_out) begin
            req_n    <= req_n + 1;
            last_req <= mif.mem_addr_out;
        end
        if (mif2.mem_req_out) req2_n <= req2_n + 1;
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_cnt <= '0;
        end else if (cnt != prev_cnt) begin
            chk("sb_step", 32'(cnt), 32'(prev_cnt + 16'd1));
            if (sb.size() == 0) chk("sb_empty", sb.size(), 1);
            else chk("sb_data", 32'(bus_data), 32'(sb.pop_front()));
            prev_cnt <= cnt;
        end
    end

    initial begin
        int          r0;
        logic [15:0] c0;
        logic [15:0] ad;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_data", 32'(bus_data), 32'hFF);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cnt", 32'(cnt), 0);
        chk("rst_ahi", 32'(ahi), 0);
        chk("rst_maddr", 32'(mif.mem_addr_out), 0);
        chk("rst_mreq", 32'(mif.mem_req_out), 0);

        repeat (20) @(posedge clk);
        #1;
        chk("idle_req", req_n, 0);
        chk("idle_data", 32'(bus_data), 32'hFF);
        chk("idle_busy", 32'(busy), 0);

        lat = 1;
        r0 = req_n;
        sb.push_back(8'hA5);
        rd_present(1'b0, 16'h1234);
        repeat (7) @(posedge clk);
        #1 chk("lat_early", 32'(bus_data), 32'hFF);
        @(posedge clk);
        #1 chk("lat_data", 32'(bus_data), 32'hA5);
        chk("lat_cnt", 32'(cnt), 1);
        chk("lat_nreq", req_n - r0, 1);
        chk("lat_addr", 32'(last_req), 32'h1234);
        chk("lat_ahi", 32'(ahi), 32'h12);

        for (int i = 0; i < 512; i++) begin
            ad  = 16'(i);
            lat = $urandom_range(1, 16);
            sb.push_back(mem_fn(ad));
            rd_present(1'b0, ad);
            repeat (24) @(posedge clk);
            #1 chk("sweep", 32'(bus_data), 32'(mem_fn(ad)));
        end
        chk("sweep_last", 32'(mif.mem_addr_out), 32'h01FF);
        chk("sweep_drain", sb.size(), 0);

        rd_present(1'b1, 16'h0100);
        for (int i = 0; i < 40 && cnt2 != 16'd1; i++) @(posedge clk);
        #1;
        chk("oor_cnt", 32'(cnt2), 1);
        chk("oor_req", req2_n, 0);
        chk("oor_data", 32'(bus2_data), 32'hFF);
        chk("oor_ahi", 32'(ahi2), 32'h01);

        lat = 10;
        r0 = req_n;
        c0 = cnt;
        sb.push_back(mem_fn(16'h0511));
        rd_present(1'b0, 16'h0510);
        for (int i = 0; i < 30 && req_n == r0; i++) @(posedge clk);
        chk("disc_req1", 32'(last_req), 32'h0510);
        @(posedge clk);
        #1 bus_addr = 8'h11;
        for (int i = 0; i < 80 && cnt == c0; i++) @(posedge clk);
        #1;
        chk("disc_cnt", 32'(cnt), 32'(c0 + 16'd1));
        chk("disc_nreq", req_n - r0, 2);
        chk("disc_req2", 32'(last_req), 32'h0511);
        chk("disc_data", 32'(bus_data), 32'h14);

        r0 = req_n;
        c0 = cnt;
        rd_present(1'b0, 16'h0511);
        repeat (30) @(posedge clk);
        #1;
        chk("same_nreq", req_n - r0, 0);
        chk("same_cnt", 32'(cnt), 32'(c0));
        chk("same_data", 32'(bus_data), 32'h14);

        lat = 10;
        r0 = req_n;
        rd_present(1'b0, 16'h0777);
        for (int i = 0; i < 30 && req_n == r0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus_addr = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("mrst_cnt", 32'(cnt), 0);
        chk("mrst_data", 32'(bus_data), 32'hFF);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_nreq", req_n - r0, 1);
        chk("sb_drain", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
